// File: rtl/tile_game_pkg.sv
// Shared types and defaults for the piano-tiles controller.
// The lane, lives and edge defaults are also used by the draw and check engines.
package tile_game_pkg;

    localparam int DEF_NUM_LANES   = 4;
    localparam int DEF_LIVES       = 3;
    localparam int DEF_EDGE_OFFSET = 40;

    typedef enum logic [3:0] {
        ST_IDLE      = 4'd0,
        ST_CLEAR     = 4'd1,
        ST_CHECK     = 4'd2,
        ST_HIT       = 4'd3,
        ST_MISS      = 4'd4,
        ST_EDGE_DET  = 4'd5,
        ST_EDGE_CHK  = 4'd6,
        ST_EDGE      = 4'd7,
        ST_EDGE_FAIL = 4'd8,
        ST_DRAW      = 4'd9,
        ST_WAIT      = 4'd10,
        ST_ADVANCE   = 4'd11,
        ST_PAUSED    = 4'd12,
        ST_GAME_OVER = 4'd13
    } state_e;

endpackage

// File: rtl/tile_game_if.sv
// Go/done handshake bundle between the game controller and its engines.
// The check engine's verdicts travel with its done pulse.
interface tile_game_if;

    logic clear_go,   clear_done;
    logic check_go,   check_done;
    logic hit_go,     hit_done;
    logic miss_go,    miss_done;
    logic draw_go,    draw_done;
    logic wait_go,    wait_done;
    logic fail_go,    fail_done;
    logic edge_go;
    logic advance_go;
    logic correct;
    logic incorrect;

    modport master (
        output clear_go, check_go, hit_go, miss_go, edge_go,
        output draw_go, wait_go, advance_go, fail_go,
        input  clear_done, check_done, hit_done, miss_done,
        input  draw_done, wait_done, fail_done,
        input  correct, incorrect
    );

    modport slave (
        input  clear_go, check_go, hit_go, miss_go, edge_go,
        input  draw_go, wait_go, advance_go, fail_go,
        output clear_done, check_done, hit_done, miss_done,
        output draw_done, wait_done, fail_done,
        output correct, incorrect
    );

endinterface

// File: rtl/tile_game_stats.sv
// Score, lives, hidden hit counter and speed level for one game.
// Strobes come from the controller FSM; load starts a fresh game.
module tile_game_stats
    import tile_game_pkg::*;
#(
    parameter int LIVES          = DEF_LIVES,
    parameter int SCORE_W        = 10,
    parameter int HITS_PER_LEVEL = 8,
    parameter int MAX_LEVEL      = 3
) (
    input  logic               clk,
    input  logic               resetn,
    input  logic               load_i,
    input  logic               hit_i,
    input  logic               miss_i,
    output logic [SCORE_W-1:0] score_o,
    output logic [2:0]         lives_o,
    output logic [1:0]         level_o,
    output logic               lives_zero_next_o
);

    localparam int HC_W =
        (HITS_PER_LEVEL > 1) ? $clog2(HITS_PER_LEVEL) : 1;

    logic [SCORE_W-1:0] score_q;
    logic [2:0]         lives_q;
    logic [1:0]         level_q;
    logic [HC_W-1:0]    hits_q;

    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            score_q <= '0;
            lives_q <= 3'(LIVES);
            level_q <= '0;
            hits_q  <= '0;
        end else if (load_i) begin
            score_q <= '0;
            lives_q <= 3'(LIVES);
            level_q <= '0;
            hits_q  <= '0;
        end else begin
            if (hit_i) begin
                if (score_q != '1)
                    score_q <= score_q + 1'b1;
                if (hits_q == HC_W'(HITS_PER_LEVEL - 1)) begin
                    hits_q <= '0;
                    if (level_q < 2'(MAX_LEVEL))
                        level_q <= level_q + 1'b1;
                end else begin
                    hits_q <= hits_q + 1'b1;
                end
            end
            if (miss_i && lives_q != '0)
                lives_q <= lives_q - 1'b1;
        end
    end

    assign score_o           = score_q;
    assign lives_o           = lives_q;
    assign level_o           = level_q;
    // Combined with a miss strobe this means the game ends this cycle
    assign lives_zero_next_o = (lives_q <= 3'd1);

endmodule

// File: rtl/tile_game_ctrl.sv
// Master FSM for the piano-tiles game: sequences the engines via go/done.
// Adds lives, saturating score, speed level and pause on top of the base flow.
module tile_game_ctrl
    import tile_game_pkg::*;
#(
    parameter int NUM_LANES      = DEF_NUM_LANES,
    parameter int OFFSET_W       = 6,
    parameter int EDGE_OFFSET    = DEF_EDGE_OFFSET,
    parameter int LIVES          = DEF_LIVES,
    parameter int SCORE_W        = 10,
    parameter int HITS_PER_LEVEL = 8,
    parameter int MAX_LEVEL      = 3
) (
    input  logic                 clk,
    input  logic                 resetn,
    input  logic                 startn,
    input  logic                 pause_req,
    input  logic [OFFSET_W-1:0]  offset,
    input  logic [NUM_LANES-1:0] bottom_row,
    tile_game_if.master          bus,
    output logic [SCORE_W-1:0]   score,
    output logic [2:0]           lives,
    output logic [1:0]           level,
    output logic                 busy_led,
    output logic                 game_over
);

    state_e state_q;
    logic   busy_q;
    logic   over_q;
    logic   load;
    logic   hit_stb;
    logic   miss_stb;
    logic   zero_next;

    assign load     = !startn &&
                      (state_q == ST_IDLE || state_q == ST_GAME_OVER);
    assign hit_stb  = (state_q == ST_HIT) && bus.hit_done;
    assign miss_stb = ((state_q == ST_MISS) && bus.miss_done) ||
                      ((state_q == ST_EDGE_FAIL) && bus.fail_done);

    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            state_q <= ST_IDLE;
            busy_q  <= 1'b0;
            over_q  <= 1'b0;
        end else begin
            case (state_q)
                ST_IDLE: if (!startn) begin
                    state_q <= ST_CLEAR;
                    busy_q  <= 1'b1;
                end
                ST_CLEAR: if (bus.clear_done) begin
                    state_q <= ST_CHECK;
                    busy_q  <= 1'b0;
                end
                ST_CHECK: begin
                    if (pause_req)
                        state_q <= ST_PAUSED;
                    else if (bus.check_done && bus.correct)
                        state_q <= ST_HIT;
                    else if (bus.check_done && bus.incorrect)
                        state_q <= ST_MISS;
                    else if (bus.check_done)
                        state_q <= ST_EDGE_DET;
                end
                ST_HIT: if (bus.hit_done)
                    state_q <= ST_EDGE_DET;
                ST_MISS: if (bus.miss_done) begin
                    state_q <= zero_next ? ST_GAME_OVER : ST_EDGE_DET;
                    over_q  <= zero_next;
                end
                ST_EDGE_DET:
                    state_q <= (offset == OFFSET_W'(EDGE_OFFSET)) ?
                               ST_EDGE_CHK : ST_DRAW;
                ST_EDGE_CHK:
                    state_q <= (bottom_row == '0) ? ST_EDGE : ST_EDGE_FAIL;
                ST_EDGE:
                    state_q <= ST_DRAW;
                ST_EDGE_FAIL: if (bus.fail_done) begin
                    state_q <= zero_next ? ST_GAME_OVER : ST_DRAW;
                    over_q  <= zero_next;
                end
                ST_DRAW: if (bus.draw_done)
                    state_q <= ST_WAIT;
                ST_WAIT: if (bus.wait_done)
                    state_q <= ST_ADVANCE;
                ST_ADVANCE:
                    state_q <= ST_CHECK;
                ST_PAUSED: if (pause_req)
                    state_q <= ST_CHECK;
                ST_GAME_OVER: if (!startn) begin
                    state_q <= ST_CLEAR;
                    busy_q  <= 1'b1;
                    over_q  <= 1'b0;
                end
                default: begin
                    state_q <= ST_IDLE;
                    busy_q  <= 1'b0;
                    over_q  <= 1'b0;
                end
            endcase
        end
    end

    // Engine enables decode the state register directly so reset kills them
    assign bus.clear_go   = (state_q == ST_CLEAR);
    assign bus.check_go   = (state_q == ST_CHECK);
    assign bus.hit_go     = (state_q == ST_HIT);
    assign bus.miss_go    = (state_q == ST_MISS);
    assign bus.edge_go    = (state_q == ST_EDGE);
    assign bus.fail_go    = (state_q == ST_EDGE_FAIL);
    assign bus.draw_go    = (state_q == ST_DRAW);
    assign bus.wait_go    = (state_q == ST_WAIT);
    assign bus.advance_go = (state_q == ST_ADVANCE);

    assign busy_led  = busy_q;
    assign game_over = over_q;

    tile_game_stats #(
        .LIVES          (LIVES),
        .SCORE_W        (SCORE_W),
        .HITS_PER_LEVEL (HITS_PER_LEVEL),
        .MAX_LEVEL      (MAX_LEVEL)
    ) u_stats (
        .clk               (clk),
        .resetn            (resetn),
        .load_i            (load),
        .hit_i             (hit_stb),
        .miss_i            (miss_stb),
        .score_o           (score),
        .lives_o           (lives),
        .level_o           (level),
        .lives_zero_next_o (zero_next)
    );

endmodule

// File: tb/tb_tile_game_ctrl.sv
// Directed bench for tile_game_ctrl: start, hits, levels, edges, lives,
// pause, score saturation and asynchronous reset.
module tb_tile_game_ctrl;

    logic       clk = 1'b0;
    logic       resetn;
    logic       startn;
    logic       pause_req;
    logic [5:0] offset;
    logic [3:0] bottom_row;
    logic [9:0] score;
    logic [2:0] lives;
    logic [1:0] level;
    logic       busy_led;
    logic       game_over;

    int n_chk  = 0;
    int n_fail = 0;

    tile_game_if bus ();

    tile_game_ctrl dut (
        .clk        (clk),
        .resetn     (resetn),
        .startn     (startn),
        .pause_req  (pause_req),
        .offset     (offset),
        .bottom_row (bottom_row),
        .bus        (bus.master),
        .score      (score),
        .lives      (lives),
        .level      (level),
        .busy_led   (busy_led),
        .game_over  (game_over)
    );

    always #5 clk = ~clk;

    wire any_go = bus.clear_go | bus.check_go | bus.hit_go |
                  bus.miss_go | bus.edge_go | bus.fail_go |
                  bus.draw_go | bus.wait_go | bus.advance_go;

    task automatic chk(input string tag, input logic [31:0] obs,
                       input logic [31:0] exp);
        n_chk++;
        if (obs !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0d expected %0d", tag, obs, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic idle_inputs();
        bus.clear_done = 0; bus.check_done = 0; bus.hit_done  = 0;
        bus.miss_done  = 0; bus.draw_done  = 0; bus.wait_done = 0;
        bus.fail_done  = 0; bus.correct    = 0; bus.incorrect = 0;
        pause_req = 0;
    endtask

    // DRAW -> WAIT -> ADVANCE -> CHECK
    task automatic finish_row();
        bus.draw_done = 1; step(); bus.draw_done = 0;
        bus.wait_done = 1; step(); bus.wait_done = 0;
        step();
    endtask

    // CHECK -> HIT -> EDGE_DET -> DRAW ... -> CHECK with offset off-edge
    task automatic hit_round(input bit both);
        bus.correct = 1; bus.incorrect = both; bus.check_done = 1;
        step(); idle_inputs();
        bus.hit_done = 1; step(); bus.hit_done = 0;
        step();
        finish_row();
    endtask

    task automatic miss_round();
        bus.incorrect = 1; bus.check_done = 1;
        step(); idle_inputs();
        bus.miss_done = 1; step(); bus.miss_done = 0;
        if (!game_over) begin
            step();
            finish_row();
        end
    endtask

    task automatic start_game();
        startn = 0; step(); startn = 1;
        bus.clear_done = 1; step(); bus.clear_done = 0;
    endtask

    initial begin
        resetn = 0; startn = 1; offset = 6'd12; bottom_row = '0;
        idle_inputs();
        #12;
        chk("rst_go", 32'(any_go), 0);
        chk("rst_score", 32'(score), 0);
        chk("rst_lives", 32'(lives), 3);
        chk("rst_level", 32'(level), 0);
        chk("rst_busy", 32'(busy_led), 0);
        chk("rst_over", 32'(game_over), 0);
        @(negedge clk); resetn = 1;
        step();
        chk("idle_hold", 32'(any_go), 0);

        startn = 0; step(); startn = 1;
        chk("clear_go", 32'(bus.clear_go), 1);
        chk("busy_on", 32'(busy_led), 1);
        bus.check_done = 1; bus.correct = 1; step(); idle_inputs();
        chk("clear_stay", 32'(bus.clear_go), 1);
        bus.clear_done = 1; step(); bus.clear_done = 0;
        chk("check_go", 32'(bus.check_go), 1);
        chk("busy_off", 32'(busy_led), 0);
        chk("start_lives", 32'(lives), 3);
        chk("start_score", 32'(score), 0);

        bus.correct = 1; bus.check_done = 1; step(); idle_inputs();
        chk("hit_go", 32'(bus.hit_go), 1);
        bus.hit_done = 1; step(); bus.hit_done = 0;
        chk("score1", 32'(score), 1);
        chk("edet_nogo", 32'(any_go), 0);
        step();
        chk("draw_go", 32'(bus.draw_go), 1);
        chk("no_edge", 32'(bus.edge_go), 0);
        bus.draw_done = 1; step(); bus.draw_done = 0;
        chk("wait_go", 32'(bus.wait_go), 1);
        bus.wait_done = 1; step(); bus.wait_done = 0;
        chk("adv_go", 32'(bus.advance_go), 1);
        step();
        chk("back_check", 32'(bus.check_go), 1);

        for (int i = 0; i < 7; i++) hit_round(0);
        chk("level8", 32'(level), 1);
        for (int i = 0; i < 8; i++) hit_round(0);
        chk("level16", 32'(level), 2);
        for (int i = 0; i < 8; i++) hit_round(0);
        chk("level24", 32'(level), 3);
        for (int i = 0; i < 8; i++) hit_round(0);
        chk("level32", 32'(level), 3);
        chk("score32", 32'(score), 32);

        bus.correct = 1; bus.incorrect = 1; bus.check_done = 1;
        step(); idle_inputs();
        chk("prio_hit", 32'(bus.hit_go), 1);
        chk("prio_nomiss", 32'(bus.miss_go), 0);
        bus.hit_done = 1; step(); bus.hit_done = 0;
        step(); finish_row();
        chk("score33", 32'(score), 33);

        offset = 6'd40; bottom_row = 4'b0000;
        bus.check_done = 1; step(); idle_inputs();
        step();
        chk("echk_nogo", 32'(any_go), 0);
        step();
        chk("edge_go", 32'(bus.edge_go), 1);
        step();
        chk("edge_draw", 32'(bus.draw_go), 1);
        chk("edge_1cyc", 32'(bus.edge_go), 0);
        finish_row();

        bottom_row = 4'b0100;
        bus.check_done = 1; step(); idle_inputs();
        step(); step();
        chk("fail_go", 32'(bus.fail_go), 1);
        step();
        chk("fail_hold", 32'(bus.fail_go), 1);
        bus.fail_done = 1; step(); bus.fail_done = 0;
        chk("fail_lives", 32'(lives), 2);
        chk("fail_draw", 32'(bus.draw_go), 1);
        finish_row();
        offset = 6'd12; bottom_row = '0;

        pause_req = 1; step(); pause_req = 0;
        chk("paused_go", 32'(any_go), 0);
        bus.check_done = 1; bus.correct = 1; step(); idle_inputs();
        chk("paused_ign", 32'(any_go), 0);
        chk("paused_score", 32'(score), 33);
        pause_req = 1; step(); pause_req = 0;
        chk("unpause", 32'(bus.check_go), 1);

        miss_round();
        chk("miss_lives1", 32'(lives), 1);
        miss_round();
        chk("miss_lives0", 32'(lives), 0);
        chk("over1", 32'(game_over), 1);
        chk("over_go", 32'(any_go), 0);
        step();
        chk("over_hold", 32'(game_over), 1);

        startn = 0; step(); startn = 1;
        chk("restart_clr", 32'(bus.clear_go), 1);
        chk("restart_lives", 32'(lives), 3);
        chk("restart_score", 32'(score), 0);
        chk("restart_level", 32'(level), 0);
        chk("restart_over", 32'(game_over), 0);
        bus.clear_done = 1; step(); bus.clear_done = 0;

        miss_round();
        chk("g2_lives2", 32'(lives), 2);
        miss_round();
        chk("g2_lives1", 32'(lives), 1);
        chk("g2_notover", 32'(game_over), 0);
        miss_round();
        chk("g2_lives0", 32'(lives), 0);
        chk("g2_over", 32'(game_over), 1);

        start_game();
        for (int i = 0; i < 1030; i++) hit_round(0);
        chk("score_sat", 32'(score), 1023);
        chk("level_sat", 32'(level), 3);

        bus.check_done = 1; step(); idle_inputs();
        step();
        chk("pre_rst_draw", 32'(bus.draw_go), 1);
        #2 resetn = 0;
        #1;
        chk("async_draw", 32'(bus.draw_go), 0);
        chk("async_go", 32'(any_go), 0);
        chk("async_score", 32'(score), 0);
        chk("async_lives", 32'(lives), 3);
        @(negedge clk); resetn = 1;
        step();
        chk("post_rst_idle", 32'(any_go), 0);

        $display("End of test - %0d assertions evaluated, %0d failures",
                 n_chk, n_fail);
        $finish;
    end

endmodule
